// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo_pkg
// Brief    : Shared FIFO mode selection for the sync and async FIFO tops.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sdp_ram.sv
`default_nettype none
// ============================================================================
// Module   : sdp_ram
// Brief    : Single-clock simple dual-port RAM with registered read port.
// Revision : 1.0
// ============================================================================
module sdp_ram #(
  parameter int unsigned Depth    = 8,
  parameter int unsigned Width    = 4,
  parameter int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_we,
  input  logic [PtrWidth-1:0] i_waddr,
  input  logic [Width-1:0]    i_wdata,
  input  logic                i_re,
  input  logic [PtrWidth-1:0] i_raddr,
  output logic [Width-1:0]    o_rdata
);

  logic [Width-1:0] r_mem [Depth];
  logic [Width-1:0] r_rdata;

  // Array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule : sdp_ram
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, standard or first-word-fall-through, any depth.
// Revision : 1.0
// ============================================================================
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned Depth    = 8,
  parameter int unsigned Width    = 4,
  parameter fifo_mode_e  Mode     = FIFO_STD,
  parameter int unsigned AfThresh = Depth - 1,
  parameter int unsigned AeThresh = 1,
  parameter int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1,
  parameter int unsigned CntWidth = $clog2(Depth + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_wr_en,
  input  logic [Width-1:0]    i_wr_data,
  output logic                o_full,
  output logic                o_almost_full,
  output logic                o_wr_overflow,
  input  logic                i_rd_en,
  output logic [Width-1:0]    o_rd_data,
  output logic                o_rd_valid,
  output logic                o_empty,
  output logic                o_almost_empty,
  output logic                o_rd_underflow,
  output logic [CntWidth-1:0] o_count
);

  localparam logic [PtrWidth-1:0] c_PTR_LAST = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] c_DEPTH    = CntWidth'(Depth);
  localparam logic [CntWidth-1:0] c_AF       = CntWidth'(AfThresh);
  localparam logic [CntWidth-1:0] c_AE       = CntWidth'(AeThresh);

  if (Depth < 2) begin : g_chk_depth
    $error("sync_fifo: Depth must be >= 2");
  end
  if (AfThresh > Depth) begin : g_chk_af
    $error("sync_fifo: AfThresh must be <= Depth");
  end
  if (AeThresh >= Depth) begin : g_chk_ae
    $error("sync_fifo: AeThresh must be < Depth");
  end

  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;
  logic                r_full;
  logic                r_empty;
  logic                r_afull;
  logic                r_aempty;
  logic                r_ovf;
  logic                r_unf;

  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [CntWidth-1:0] w_count_nxt;
  logic [PtrWidth-1:0] w_wr_ptr_nxt;
  logic [PtrWidth-1:0] w_rd_ptr_nxt;

  logic                w_ram_we;
  logic                w_ram_pop;
  logic                w_ram_re;
  logic [PtrWidth-1:0] w_ram_raddr;
  logic [Width-1:0]    w_ram_rdata;

  // Acceptance uses registered flags only, so a same-cycle pop never frees a slot for a write.
  assign w_wr_acc = i_wr_en && !r_full;
  assign w_rd_acc = i_rd_en && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_acc && !w_rd_acc) begin
      w_count_nxt = r_count + CntWidth'(1);
    end else if (!w_wr_acc && w_rd_acc) begin
      w_count_nxt = r_count - CntWidth'(1);
    end
  end

  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    if (w_ram_we) begin
      w_wr_ptr_nxt = (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + PtrWidth'(1);
    end
  end

  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_ram_pop) begin
      w_rd_ptr_nxt = (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + PtrWidth'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= (AfThresh == 0);
      r_aempty <= 1'b1;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == c_DEPTH);
      r_empty  <= (w_count_nxt == '0);
      r_afull  <= (w_count_nxt >= c_AF);
      r_aempty <= (w_count_nxt <= c_AE);
      r_ovf    <= i_wr_en && r_full;
      r_unf    <= i_rd_en && r_empty;
    end
  end

  sdp_ram #(
    .Depth    (Depth),
    .Width    (Width),
    .PtrWidth (PtrWidth)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_ram_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (i_wr_data),
    .i_re    (w_ram_re),
    .i_raddr (w_ram_raddr),
    .o_rdata (w_ram_rdata)
  );

  if (Mode == FIFO_FWFT) begin : g_fwft
    logic [Width-1:0]    r_head_data;
    logic                r_head_valid;
    logic [Width-1:0]    r_byp_data;
    logic                r_stale;
    logic [CntWidth-1:0] w_ram_cnt;
    logic                w_fill;
    logic                w_from_ram;
    logic                w_bypass;
    logic [Width-1:0]    w_ram_head;

    assign w_ram_cnt  = r_count - CntWidth'(r_head_valid);
    assign w_fill     = !r_head_valid || w_rd_acc;
    assign w_from_ram = w_fill && (w_ram_cnt != '0);
    assign w_bypass   = w_fill && (w_ram_cnt == '0) && w_wr_acc;

    // The RAM prefetches the entry at the next read pointer every cycle; if that
    // same slot was written on the same edge the read returned old contents, so
    // the written word is kept aside for one cycle and used instead.
    assign w_ram_head  = r_stale ? r_byp_data : w_ram_rdata;
    assign w_ram_we    = w_wr_acc && !w_bypass;
    assign w_ram_pop   = w_from_ram;
    assign w_ram_re    = 1'b1;
    assign w_ram_raddr = w_rd_ptr_nxt;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_head_data  <= '0;
        r_head_valid <= 1'b0;
        r_byp_data   <= '0;
        r_stale      <= 1'b0;
      end else begin
        r_stale    <= w_ram_we && (r_wr_ptr == w_rd_ptr_nxt);
        r_byp_data <= i_wr_data;
        if (w_from_ram) begin
          r_head_data  <= w_ram_head;
          r_head_valid <= 1'b1;
        end else if (w_bypass) begin
          r_head_data  <= i_wr_data;
          r_head_valid <= 1'b1;
        end else if (w_fill) begin
          r_head_valid <= 1'b0;
        end
      end
    end

    assign o_rd_data  = r_head_data;
    assign o_rd_valid = r_head_valid;
  end else begin : g_std
    logic r_rd_valid;

    assign w_ram_we    = w_wr_acc;
    assign w_ram_pop   = w_rd_acc;
    assign w_ram_re    = w_rd_acc;
    assign w_ram_raddr = r_rd_ptr;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_acc;
      end
    end

    assign o_rd_data  = w_ram_rdata;
    assign o_rd_valid = r_rd_valid;
  end

  assign o_full         = r_full;
  assign o_almost_full  = r_afull;
  assign o_wr_overflow  = r_ovf;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_aempty;
  assign o_rd_underflow = r_unf;
  assign o_count        = r_count;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Brief    : Directed bench for sync_fifo in STD (depth 8) and FWFT (depth 8, 5).
// Revision : 1.0
// ============================================================================
module tb_sync_fifo;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // STD, depth 8
  logic s_wr_en = 1'b0, s_rd_en = 1'b0;
  logic [3:0] s_wr_data = '0, s_rd_data;
  logic s_full, s_afull, s_ovf, s_valid, s_empty, s_aempty, s_unf;
  logic [3:0] s_count;

  // FWFT, depth 8
  logic f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [3:0] f_wr_data = '0, f_rd_data;
  logic f_full, f_afull, f_ovf, f_valid, f_empty, f_aempty, f_unf;
  logic [3:0] f_count;

  // FWFT, depth 5
  logic g_wr_en = 1'b0, g_rd_en = 1'b0;
  logic [4:0] g_wr_data = '0, g_rd_data;
  logic g_full, g_afull, g_ovf, g_valid, g_empty, g_aempty, g_unf;
  logic [2:0] g_count;

  sync_fifo #(.Depth(8), .Width(4), .Mode(FIFO_STD)) u_std (
    .clk(clk), .rst(rst),
    .i_wr_en(s_wr_en), .i_wr_data(s_wr_data),
    .o_full(s_full), .o_almost_full(s_afull), .o_wr_overflow(s_ovf),
    .i_rd_en(s_rd_en), .o_rd_data(s_rd_data), .o_rd_valid(s_valid),
    .o_empty(s_empty), .o_almost_empty(s_aempty), .o_rd_underflow(s_unf),
    .o_count(s_count)
  );

  sync_fifo #(.Depth(8), .Width(4), .Mode(FIFO_FWFT)) u_fwft8 (
    .clk(clk), .rst(rst),
    .i_wr_en(f_wr_en), .i_wr_data(f_wr_data),
    .o_full(f_full), .o_almost_full(f_afull), .o_wr_overflow(f_ovf),
    .i_rd_en(f_rd_en), .o_rd_data(f_rd_data), .o_rd_valid(f_valid),
    .o_empty(f_empty), .o_almost_empty(f_aempty), .o_rd_underflow(f_unf),
    .o_count(f_count)
  );

  sync_fifo #(.Depth(5), .Width(5), .Mode(FIFO_FWFT)) u_fwft5 (
    .clk(clk), .rst(rst),
    .i_wr_en(g_wr_en), .i_wr_data(g_wr_data),
    .o_full(g_full), .o_almost_full(g_afull), .o_wr_overflow(g_ovf),
    .i_rd_en(g_rd_en), .o_rd_data(g_rd_data), .o_rd_valid(g_valid),
    .o_empty(g_empty), .o_almost_empty(g_aempty), .o_rd_underflow(g_unf),
    .o_count(g_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    chk("rst_s_empty",  32'(s_empty), 32'd1);
    chk("rst_s_full",   32'(s_full), 32'd0);
    chk("rst_s_count",  32'(s_count), 32'd0);
    chk("rst_s_aempty", 32'(s_aempty), 32'd1);
    chk("rst_s_afull",  32'(s_afull), 32'd0);
    chk("rst_s_valid",  32'(s_valid), 32'd0);
    chk("rst_s_data",   32'(s_rd_data), 32'd0);
    chk("rst_f_empty",  32'(f_empty), 32'd1);
    chk("rst_f_valid",  32'(f_valid), 32'd0);

    // STD: fill 0..7, then one extra write overflows
    for (int i = 0; i < 8; i++) begin
      s_wr_en = 1'b1; s_wr_data = 4'(i);
      tick();
      chk("s_fill_count", 32'(s_count), 32'(i + 1));
      chk("s_fill_empty", 32'(s_empty), 32'd0);
      chk("s_fill_aempty", 32'(s_aempty), (i == 0) ? 32'd1 : 32'd0);
      chk("s_fill_afull", 32'(s_afull), (i >= 6) ? 32'd1 : 32'd0);
      chk("s_fill_full",  32'(s_full), (i == 7) ? 32'd1 : 32'd0);
    end
    s_wr_data = 4'hF;
    tick();
    chk("s_ovf_pulse", 32'(s_ovf), 32'd1);
    chk("s_ovf_count", 32'(s_count), 32'd8);
    s_wr_en = 1'b0;
    tick();
    chk("s_ovf_clear", 32'(s_ovf), 32'd0);

    // STD: drain 0..7 with one-cycle latency, then underflow
    for (int i = 0; i < 8; i++) begin
      s_rd_en = 1'b1;
      tick();
      chk("s_rd_valid", 32'(s_valid), 32'd1);
      chk("s_rd_data",  32'(s_rd_data), 32'(i));
      chk("s_rd_count", 32'(s_count), 32'(7 - i));
      chk("s_rd_empty", 32'(s_empty), (i == 7) ? 32'd1 : 32'd0);
    end
    tick();
    chk("s_unf_pulse", 32'(s_unf), 32'd1);
    chk("s_unf_valid", 32'(s_valid), 32'd0);
    chk("s_unf_hold",  32'(s_rd_data), 32'd7);
    s_rd_en = 1'b0;
    tick();
    chk("s_unf_clear", 32'(s_unf), 32'd0);

    // STD: write+read at empty -> write taken, read ignored
    s_wr_en = 1'b1; s_rd_en = 1'b1; s_wr_data = 4'd5;
    tick();
    chk("s_wre_count", 32'(s_count), 32'd1);
    chk("s_wre_unf",   32'(s_unf), 32'd1);
    chk("s_wre_valid", 32'(s_valid), 32'd0);
    s_rd_en = 1'b0;
    for (int i = 1; i < 8; i++) begin
      s_wr_data = 4'(i + 8);
      tick();
    end
    chk("s_full2", 32'(s_full), 32'd1);

    // STD: write+read at full -> read taken, write dropped
    s_rd_en = 1'b1; s_wr_data = 4'hE;
    tick();
    chk("s_wrf_count", 32'(s_count), 32'd7);
    chk("s_wrf_ovf",   32'(s_ovf), 32'd1);
    chk("s_wrf_data",  32'(s_rd_data), 32'd5);
    s_wr_en = 1'b0;
    tick();
    chk("s_rd9", 32'(s_rd_data), 32'd9);
    tick();
    chk("s_rd10", 32'(s_rd_data), 32'd10);
    s_rd_en = 1'b0;
    tick();
    chk("s_pre_rst_count", 32'(s_count), 32'd5);

    // STD: reset with entries held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s_mrst_count", 32'(s_count), 32'd0);
    chk("s_mrst_empty", 32'(s_empty), 32'd1);
    chk("s_mrst_valid", 32'(s_valid), 32'd0);
    s_wr_en = 1'b1; s_wr_data = 4'hC;
    tick();
    s_wr_en = 1'b0; s_rd_en = 1'b1;
    tick();
    s_rd_en = 1'b0;
    chk("s_fresh_data",  32'(s_rd_data), 32'hC);
    chk("s_fresh_empty", 32'(s_empty), 32'd1);

    // FWFT depth 8: single write visible next cycle, pop empties
    f_wr_en = 1'b1; f_wr_data = 4'hA;
    tick();
    f_wr_en = 1'b0;
    chk("f_one_data",  32'(f_rd_data), 32'hA);
    chk("f_one_valid", 32'(f_valid), 32'd1);
    chk("f_one_count", 32'(f_count), 32'd1);
    f_rd_en = 1'b1;
    tick();
    chk("f_pop_empty", 32'(f_empty), 32'd1);
    chk("f_pop_valid", 32'(f_valid), 32'd0);

    // FWFT: write+read at empty
    f_wr_en = 1'b1; f_wr_data = 4'd3;
    tick();
    f_rd_en = 1'b0;
    chk("f_wre_count", 32'(f_count), 32'd1);
    chk("f_wre_unf",   32'(f_unf), 32'd1);
    chk("f_wre_data",  32'(f_rd_data), 32'd3);
    for (int i = 4; i <= 10; i++) begin
      f_wr_data = 4'(i);
      tick();
    end
    chk("f_full", 32'(f_full), 32'd1);
    chk("f_head", 32'(f_rd_data), 32'd3);

    // FWFT: write+read at full, head refills from RAM on the pop edge
    f_rd_en = 1'b1; f_wr_data = 4'hB;
    tick();
    f_wr_en = 1'b0;
    chk("f_wrf_count", 32'(f_count), 32'd7);
    chk("f_wrf_ovf",   32'(f_ovf), 32'd1);
    chk("f_wrf_data",  32'(f_rd_data), 32'd4);
    tick();
    f_rd_en = 1'b0;
    chk("f_next_data", 32'(f_rd_data), 32'd5);

    // FWFT depth 5: prefill 1,2 then stream 20 cycles of write+read
    g_wr_en = 1'b1; g_wr_data = 5'd1;
    tick();
    g_wr_data = 5'd2;
    tick();
    chk("g_pre_count", 32'(g_count), 32'd2);
    g_rd_en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      g_wr_data = 5'(k + 3);
      chk("g_stream_data",  32'(g_rd_data), 32'(k + 1));
      chk("g_stream_valid", 32'(g_valid), 32'd1);
      tick();
      chk("g_stream_count", 32'(g_count), 32'd2);
    end
    g_wr_en = 1'b0; g_rd_en = 1'b0;
    chk("g_tail_data", 32'(g_rd_data), 32'd21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sync_fifo
`default_nettype wire
